// File: rtl/id_stage_pipe.sv
// Instruction decode stage: field decode, condition check, register file with write-through,
// per-register pending-write scoreboard, hazard detection and the ID/EX pipeline register.
module id_stage_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_N  = 16,
    parameter int unsigned CNT_W  = 2,
    localparam int unsigned AW    = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] pc,
    input  logic [3:0]        status,
    input  logic              stall_in,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    output logic              in_ready,
    output logic              hazard,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_pc,
    output logic [3:0]        exe_cmd,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic              wb_en_out,
    output logic              branch,
    output logic              s_update,
    output logic              imm,
    output logic              two_src,
    output logic [DATA_W-1:0] val_rn,
    output logic [DATA_W-1:0] val_rm,
    output logic [11:0]       shift_operand,
    output logic [23:0]       signed_imm_24,
    output logic [AW-1:0]     dest,
    output logic [AW-1:0]     rn,
    output logic [AW-1:0]     rm
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] rf [REG_N];
    logic [CNT_W-1:0]  cnt [REG_N];
    logic [CNT_W-1:0]  cnt_next [REG_N];
    logic [REG_N-1:0]  reg_busy;

    logic [3:0]    cond;
    logic [1:0]    mode;
    logic [3:0]    opcode;
    logic          i_bit;
    logic          s_bit;
    logic [AW-1:0] rn_a;
    logic [AW-1:0] rd_a;
    logic [AW-1:0] rm_a;
    logic [AW-1:0] src2_a;
    logic          is_ldr;
    logic          is_str;
    logic          two_src_d;
    logic          cond_pass;

    logic [3:0] d_exe;
    logic       d_mr;
    logic       d_mw;
    logic       d_wb;
    logic       d_br;
    logic       d_s;
    logic       e_wb;

    logic              issue;
    logic              load_bubble;
    logic [DATA_W-1:0] rd_rn;
    logic [DATA_W-1:0] rd_src2;

    assign cond      = instruction[31:28];
    assign mode      = instruction[27:26];
    assign i_bit     = instruction[25];
    assign opcode    = instruction[24:21];
    assign s_bit     = instruction[20];
    assign rn_a      = instruction[16 +: AW];
    assign rd_a      = instruction[12 +: AW];
    assign rm_a      = instruction[0 +: AW];
    assign is_ldr    = (mode == 2'b01) & s_bit;
    assign is_str    = (mode == 2'b01) & ~s_bit;
    assign two_src_d = ~(i_bit | is_ldr);
    assign src2_a    = is_str ? rd_a : rm_a;

    // Opcode/mode to control-word decode, before the condition check.
    always_comb begin
        d_exe = 4'b0000;
        d_mr  = 1'b0;
        d_mw  = 1'b0;
        d_wb  = 1'b0;
        d_br  = 1'b0;
        d_s   = 1'b0;
        case (mode)
            2'b00: begin
                d_wb = 1'b1;
                d_s  = s_bit;
                case (opcode)
                    4'b1101: d_exe = 4'b0001;
                    4'b1111: d_exe = 4'b1001;
                    4'b0100: d_exe = 4'b0010;
                    4'b0101: d_exe = 4'b0011;
                    4'b0010: d_exe = 4'b0100;
                    4'b0110: d_exe = 4'b0101;
                    4'b0000: d_exe = 4'b0110;
                    4'b1100: d_exe = 4'b0111;
                    4'b0001: d_exe = 4'b1000;
                    4'b1010: begin
                        d_exe = 4'b0100;
                        d_wb  = 1'b0;
                        d_s   = 1'b1;
                    end
                    4'b1000: begin
                        d_exe = 4'b0110;
                        d_wb  = 1'b0;
                        d_s   = 1'b1;
                    end
                    default: begin
                        d_wb = 1'b0;
                        d_s  = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                d_exe = 4'b0010;
                d_mr  = s_bit;
                d_mw  = ~s_bit;
                d_wb  = s_bit;
            end
            2'b10:   d_br = 1'b1;
            default: d_br = 1'b0;
        endcase
    end

    // ARM condition codes against {N,Z,C,V}.
    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = status[2];
            4'b0001: cond_pass = ~status[2];
            4'b0010: cond_pass = status[1];
            4'b0011: cond_pass = ~status[1];
            4'b0100: cond_pass = status[3];
            4'b0101: cond_pass = ~status[3];
            4'b0110: cond_pass = status[0];
            4'b0111: cond_pass = ~status[0];
            4'b1000: cond_pass = status[1] & ~status[2];
            4'b1001: cond_pass = ~status[1] | status[2];
            4'b1010: cond_pass = (status[3] == status[0]);
            4'b1011: cond_pass = (status[3] != status[0]);
            4'b1100: cond_pass = ~status[2] & (status[3] == status[0]);
            4'b1101: cond_pass = status[2] | (status[3] != status[0]);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    assign e_wb = d_wb & cond_pass;

    // A register is busy unless its last outstanding write lands this cycle.
    always_comb begin
        reg_busy = '0;
        for (int unsigned r = 0; r < REG_N; r++) begin
            reg_busy[r] = (cnt[AW'(r)] != '0) &&
                          !((cnt[AW'(r)] == CNT_W'(1)) && wb_en && (wb_dest == AW'(r)));
        end
    end

    assign hazard = in_valid & (((mode != 2'b10) & reg_busy[rn_a]) |
                                ((two_src_d | is_str) & reg_busy[src2_a]) |
                                (e_wb & (cnt[rd_a] == CNT_MAX)));
    assign in_ready    = ~stall_in & ~hazard;
    assign issue       = in_valid & in_ready & ~flush;
    assign load_bubble = flush | (~stall_in & ~issue);

    assign rd_rn   = (wb_en && (wb_dest == rn_a))   ? wb_value : rf[rn_a];
    assign rd_src2 = (wb_en && (wb_dest == src2_a)) ? wb_value : rf[src2_a];

    function automatic logic [CNT_W-1:0] cnt_upd(input logic [CNT_W-1:0] c, input logic inc,
                                                 input logic dec_a, input logic dec_b);
        logic [CNT_W:0] s;
        s = {1'b0, c} + (CNT_W+1)'(inc);
        if (dec_a && (s != '0)) s = s - (CNT_W+1)'(1);
        if (dec_b && (s != '0)) s = s - (CNT_W+1)'(1);
        return CNT_W'(s);
    endfunction

    // Scoreboard next state: issue increments, write-back and flushed writers decrement.
    always_comb begin
        for (int unsigned r = 0; r < REG_N; r++) begin
            cnt_next[r] = cnt_upd(cnt[AW'(r)],
                                  issue & e_wb & (rd_a == AW'(r)),
                                  wb_en & (wb_dest == AW'(r)),
                                  flush & out_valid & wb_en_out & (dest == AW'(r)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < REG_N; r++) begin
                rf[AW'(r)]  <= '0;
                cnt[AW'(r)] <= '0;
            end
        end else begin
            if (wb_en) rf[wb_dest] <= wb_value;
            for (int unsigned r = 0; r < REG_N; r++) begin
                cnt[AW'(r)] <= cnt_next[r];
            end
        end
    end

    // ID/EX register: load on issue, bubble when idle or flushed, hold while stalled.
    always_ff @(posedge clk) begin
        if (rst || load_bubble) begin
            out_valid     <= 1'b0;
            out_pc        <= '0;
            exe_cmd       <= '0;
            mem_r_en      <= 1'b0;
            mem_w_en      <= 1'b0;
            wb_en_out     <= 1'b0;
            branch        <= 1'b0;
            s_update      <= 1'b0;
            imm           <= 1'b0;
            two_src       <= 1'b0;
            val_rn        <= '0;
            val_rm        <= '0;
            shift_operand <= '0;
            signed_imm_24 <= '0;
            dest          <= '0;
            rn            <= '0;
            rm            <= '0;
        end else if (issue) begin
            out_valid     <= 1'b1;
            out_pc        <= pc;
            exe_cmd       <= d_exe;
            mem_r_en      <= d_mr & cond_pass;
            mem_w_en      <= d_mw & cond_pass;
            wb_en_out     <= e_wb;
            branch        <= d_br & cond_pass;
            s_update      <= d_s & cond_pass;
            imm           <= i_bit;
            two_src       <= two_src_d;
            val_rn        <= rd_rn;
            val_rm        <= rd_src2;
            shift_operand <= instruction[11:0];
            signed_imm_24 <= instruction[23:0];
            dest          <= rd_a;
            rn            <= rn_a;
            rm            <= src2_a;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: decode table, directed pipeline sequences, and random traffic
// checked against a cycle-level reference model.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, stall_in, flush, wb_en;
    logic [31:0] instruction, pc, wb_value;
    logic [3:0]  status, wb_dest;
    logic        in_ready, hazard, out_valid, mem_r_en, mem_w_en, wb_en_out;
    logic        branch, s_update, imm, two_src;
    logic [31:0] out_pc, val_rn, val_rm;
    logic [3:0]  exe_cmd, dest, rn, rm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction), .pc(pc),
        .status(status), .stall_in(stall_in), .flush(flush), .wb_en(wb_en),
        .wb_dest(wb_dest), .wb_value(wb_value), .in_ready(in_ready), .hazard(hazard),
        .out_valid(out_valid), .out_pc(out_pc), .exe_cmd(exe_cmd), .mem_r_en(mem_r_en),
        .mem_w_en(mem_w_en), .wb_en_out(wb_en_out), .branch(branch), .s_update(s_update),
        .imm(imm), .two_src(two_src), .val_rn(val_rn), .val_rm(val_rm),
        .shift_operand(shift_operand), .signed_imm_24(signed_imm_24), .dest(dest),
        .rn(rn), .rm(rm)
    );

    typedef struct packed {
        logic [3:0] exe;
        logic       mr, mw, wb, br, s;
    } ctl_t;

    typedef struct {
        logic [31:0] ins;
        logic [3:0]  st;
        logic [9:0]  exp;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0]  m_rf [16];
    int           m_cnt [16];
    logic [155:0] m_out;
    logic         m_valid, m_wbo;
    logic [3:0]   m_dest;
    logic         haz_seen, rdy_seen;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [3:0] cnd, input logic [1:0] md,
                                        input logic i, input logic [3:0] op, input logic s,
                                        input logic [3:0] a, input logic [3:0] d,
                                        input logic [11:0] op2);
        return {cnd, md, i, op, s, a, d, op2};
    endfunction

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] st);
        bit n, z, cy, v;
        {n, z, cy, v} = st;
        case (c)
            4'h0: return z;              4'h1: return !z;
            4'h2: return cy;             4'h3: return !cy;
            4'h4: return n;              4'h5: return !n;
            4'h6: return v;              4'h7: return !v;
            4'h8: return cy && !z;       4'h9: return !cy || z;
            4'hA: return n == v;         4'hB: return n != v;
            4'hC: return !z && n == v;   4'hD: return z || n != v;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Architectural meaning of an instruction: control word after the condition test.
    function automatic ctl_t ref_ctl(input logic [31:0] ins, input logic [3:0] st);
        ctl_t c;
        logic s;
        s = ins[20];
        c = '0;
        if (ins[27:26] == 2'b00) begin
            case (ins[24:21])
                4'hD: c = '{4'd1, 1'b0, 1'b0, 1'b1, 1'b0, s};
                4'hF: c = '{4'd9, 1'b0, 1'b0, 1'b1, 1'b0, s};
                4'h4: c = '{4'd2, 1'b0, 1'b0, 1'b1, 1'b0, s};
                4'h5: c = '{4'd3, 1'b0, 1'b0, 1'b1, 1'b0, s};
                4'h2: c = '{4'd4, 1'b0, 1'b0, 1'b1, 1'b0, s};
                4'h6: c = '{4'd5, 1'b0, 1'b0, 1'b1, 1'b0, s};
                4'h0: c = '{4'd6, 1'b0, 1'b0, 1'b1, 1'b0, s};
                4'hC: c = '{4'd7, 1'b0, 1'b0, 1'b1, 1'b0, s};
                4'h1: c = '{4'd8, 1'b0, 1'b0, 1'b1, 1'b0, s};
                4'hA: c = '{4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
                4'h8: c = '{4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
                default: c = '0;
            endcase
        end else if (ins[27:26] == 2'b01) begin
            c = s ? '{4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0} : '{4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        end else if (ins[27:26] == 2'b10) begin
            c.br = 1'b1;
        end
        if (!cond_ok(ins[31:28], st)) begin
            c.mr = 0; c.mw = 0; c.wb = 0; c.br = 0; c.s = 0;
        end
        return c;
    endfunction

    function automatic bit busy(input logic [3:0] r);
        return m_cnt[r] != 0 && !(m_cnt[r] == 1 && wb_en && wb_dest == r);
    endfunction

    function automatic logic [31:0] rdval(input logic [3:0] r);
        return (wb_en && wb_dest == r) ? wb_value : m_rf[r];
    endfunction

    function automatic logic [155:0] pack_dut();
        return {out_valid, exe_cmd, mem_r_en, mem_w_en, wb_en_out, branch, s_update, imm,
                two_src, out_pc, val_rn, val_rm, shift_operand, signed_imm_24, dest, rn, rm};
    endfunction

    task automatic idle();
        rst = 0; in_valid = 0; instruction = '0; pc = '0; status = '0;
        stall_in = 0; flush = 0; wb_en = 0; wb_dest = '0; wb_value = '0;
    endtask

    // One clock: check combinational outputs, advance the model, check the ID/EX register.
    task automatic cyc();
        logic [1:0]   md;
        logic         sb, two, store;
        logic [3:0]   rnf, rdf, rmf, s2;
        ctl_t         c;
        bit           iss;
        logic [155:0] nxt;
        int           nc [16];
        bit           m_haz, m_rdy;
        #1;
        md    = instruction[27:26];
        sb    = instruction[20];
        rnf   = instruction[19:16];
        rdf   = instruction[15:12];
        rmf   = instruction[3:0];
        store = (md == 2'b01) && !sb;
        s2    = store ? rdf : rmf;
        two   = !(instruction[25] || (md == 2'b01 && sb));
        c     = ref_ctl(instruction, status);
        m_haz = in_valid && ((md != 2'b10 && busy(rnf)) || ((two || store) && busy(s2)) ||
                             (c.wb && m_cnt[rdf] == 3));
        m_rdy = !stall_in && !m_haz;
        haz_seen = hazard;
        rdy_seen = in_ready;
        chk("hazard", hazard, m_haz);
        chk("in_ready", in_ready, m_rdy);
        iss = in_valid && m_rdy && !flush;
        nxt = {1'b1, c, instruction[25], two, pc, rdval(rnf), rdval(s2), instruction[11:0],
               instruction[23:0], rdf, rnf, s2};
        for (int r = 0; r < 16; r++) begin
            nc[r] = m_cnt[r] + ((iss && c.wb && rdf == r) ? 1 : 0)
                             - ((wb_en && wb_dest == r) ? 1 : 0)
                             - ((flush && m_valid && m_wbo && m_dest == r) ? 1 : 0);
            if (nc[r] < 0) nc[r] = 0;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            for (int r = 0; r < 16; r++) begin
                m_rf[r] = '0;
                m_cnt[r] = 0;
            end
            m_out = '0; m_valid = 0; m_wbo = 0; m_dest = '0;
        end else begin
            if (wb_en) m_rf[wb_dest] = wb_value;
            m_cnt = nc;
            if (flush || (!stall_in && !iss)) begin
                m_out = '0; m_valid = 0; m_wbo = 0; m_dest = '0;
            end else if (iss) begin
                m_out = nxt; m_valid = 1; m_wbo = c.wb; m_dest = rdf;
            end
        end
        chk("idex", pack_dut(), m_out);
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        cyc();
        rst = 0;
    endtask

    vec_t         tbl [22];
    logic [155:0] held;
    localparam logic [3:0] AL = 4'hE;

    initial begin
        tbl[0]  = '{enc(AL, 2'd0, 1, 4'hD, 0, 0, 1, 12'h005), 4'h0, {1'b1, 4'd1, 5'b00100}};
        tbl[1]  = '{enc(AL, 2'd0, 0, 4'hF, 1, 0, 2, 12'h003), 4'h0, {1'b1, 4'd9, 5'b00101}};
        tbl[2]  = '{enc(AL, 2'd0, 0, 4'h4, 0, 1, 2, 12'h003), 4'h0, {1'b1, 4'd2, 5'b00100}};
        tbl[3]  = '{enc(AL, 2'd0, 0, 4'h5, 1, 1, 2, 12'h003), 4'h0, {1'b1, 4'd3, 5'b00101}};
        tbl[4]  = '{enc(AL, 2'd0, 0, 4'h2, 0, 1, 2, 12'h003), 4'h0, {1'b1, 4'd4, 5'b00100}};
        tbl[5]  = '{enc(AL, 2'd0, 0, 4'h6, 0, 1, 2, 12'h003), 4'h0, {1'b1, 4'd5, 5'b00100}};
        tbl[6]  = '{enc(AL, 2'd0, 0, 4'h0, 0, 1, 2, 12'h003), 4'h0, {1'b1, 4'd6, 5'b00100}};
        tbl[7]  = '{enc(AL, 2'd0, 0, 4'hC, 0, 1, 2, 12'h003), 4'h0, {1'b1, 4'd7, 5'b00100}};
        tbl[8]  = '{enc(AL, 2'd0, 0, 4'h1, 0, 1, 2, 12'h003), 4'h0, {1'b1, 4'd8, 5'b00100}};
        tbl[9]  = '{enc(AL, 2'd0, 0, 4'hA, 0, 1, 0, 12'h003), 4'h0, {1'b1, 4'd4, 5'b00001}};
        tbl[10] = '{enc(AL, 2'd0, 1, 4'h8, 1, 1, 0, 12'h0FF), 4'h0, {1'b1, 4'd6, 5'b00001}};
        tbl[11] = '{enc(AL, 2'd0, 0, 4'h3, 1, 1, 2, 12'h003), 4'h0, {1'b1, 4'd0, 5'b00000}};
        tbl[12] = '{enc(AL, 2'd1, 0, 4'h0, 1, 2, 3, 12'h000), 4'h0, {1'b1, 4'd2, 5'b10100}};
        tbl[13] = '{enc(AL, 2'd1, 0, 4'h0, 0, 2, 3, 12'h000), 4'h0, {1'b1, 4'd2, 5'b01000}};
        tbl[14] = '{enc(AL, 2'd2, 1, 4'h5, 1, 7, 3, 12'hABC), 4'h0, {1'b1, 4'd0, 5'b00010}};
        tbl[15] = '{enc(AL, 2'd3, 0, 4'h4, 1, 1, 2, 12'h003), 4'h0, {1'b1, 4'd0, 5'b00000}};
        tbl[16] = '{enc(4'h0, 2'd0, 0, 4'h4, 0, 1, 2, 12'h003), 4'h0, {1'b1, 4'd2, 5'b00000}};
        tbl[17] = '{enc(4'hC, 2'd0, 0, 4'h4, 0, 1, 2, 12'h003), 4'h9, {1'b1, 4'd2, 5'b00100}};
        tbl[18] = '{enc(4'hF, 2'd0, 0, 4'hA, 1, 1, 0, 12'h003), 4'h0, {1'b1, 4'd4, 5'b00000}};
        tbl[19] = '{enc(4'hB, 2'd2, 0, 4'h0, 0, 0, 0, 12'h010), 4'h8, {1'b1, 4'd0, 5'b00010}};
        tbl[20] = '{enc(4'h8, 2'd0, 0, 4'h2, 0, 1, 2, 12'h003), 4'h6, {1'b1, 4'd4, 5'b00000}};
        tbl[21] = '{enc(4'h9, 2'd0, 0, 4'h4, 0, 1, 2, 12'h003), 4'h0, {1'b1, 4'd2, 5'b00100}};

        // Reset state and first cycle after reset.
        do_reset();
        chk("rst_outs", pack_dut(), 156'h0);
        cyc();
        chk("post_rst_hazard", haz_seen, 1'b0);
        chk("post_rst_ready", rdy_seen, 1'b1);

        // ADD R1,R2,R3 with R2=5, R3=7, then dependent SUB resolved by write-back.
        wb_en = 1; wb_dest = 4'd2; wb_value = 32'd5; cyc();
        wb_dest = 4'd3; wb_value = 32'd7; cyc();
        wb_en = 0;
        in_valid = 1; pc = 32'h100;
        instruction = enc(AL, 2'd0, 0, 4'h4, 0, 2, 1, 12'h003);
        cyc();
        chk("add_valid", out_valid, 1'b1);
        chk("add_exe", exe_cmd, 4'b0010);
        chk("add_val_rn", val_rn, 32'd5);
        chk("add_val_rm", val_rm, 32'd7);
        chk("add_dest", dest, 4'd1);
        chk("add_wb", wb_en_out, 1'b1);
        instruction = enc(AL, 2'd0, 0, 4'h2, 0, 1, 5, 12'h002);
        cyc();
        chk("raw_hazard", haz_seen, 1'b1);
        chk("raw_ready", rdy_seen, 1'b0);
        chk("raw_bubble", out_valid, 1'b0);
        wb_en = 1; wb_dest = 4'd1; wb_value = 32'd12;
        cyc();
        chk("wb_release_hazard", haz_seen, 1'b0);
        chk("sub_valid", out_valid, 1'b1);
        chk("sub_val_rn", val_rn, 32'd12);
        chk("sub_exe", exe_cmd, 4'b0100);
        idle();

        // Writers to R4 fill the counter; a writer at the maximum count waits.
        do_reset();
        in_valid = 1;
        instruction = enc(AL, 2'd0, 1, 4'hD, 0, 0, 4, 12'h001);
        cyc(); cyc(); cyc();
        cyc();
        chk("cnt_full_hazard", haz_seen, 1'b1);
        chk("cnt_full_bubble", out_valid, 1'b0);
        wb_en = 1; wb_dest = 4'd4; wb_value = 32'h44;
        cyc();
        chk("cnt_full_wb_same_cycle", haz_seen, 1'b1);
        wb_en = 0;
        cyc();
        chk("cnt_after_wb_hazard", haz_seen, 1'b0);
        chk("cnt_after_wb_issue", out_valid, 1'b1);
        idle();

        // LDR with EQ failing: issues with no side effects and no pending write.
        do_reset();
        in_valid = 1; status = 4'b0000;
        instruction = enc(4'h0, 2'd1, 0, 4'h0, 1, 2, 7, 12'h000);
        cyc();
        chk("ldr_nc_valid", out_valid, 1'b1);
        chk("ldr_nc_mr", mem_r_en, 1'b0);
        chk("ldr_nc_wb", wb_en_out, 1'b0);
        instruction = enc(AL, 2'd0, 0, 4'h4, 0, 7, 8, 12'h007);
        cyc();
        chk("ldr_nc_no_hazard", haz_seen, 1'b0);
        idle();

        // Stall holds ID/EX for three cycles, then flush kills it and releases its dest.
        do_reset();
        in_valid = 1; pc = 32'h200;
        instruction = enc(AL, 2'd0, 0, 4'h4, 0, 2, 6, 12'h003);
        cyc();
        held = pack_dut();
        stall_in = 1;
        instruction = enc(AL, 2'd0, 0, 4'h4, 0, 2, 9, 12'h003);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_hold", pack_dut(), held);
        end
        flush = 1;
        cyc();
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_wb", wb_en_out, 1'b0);
        flush = 0; stall_in = 0;
        instruction = enc(AL, 2'd0, 0, 4'h2, 0, 6, 10, 12'h006);
        cyc();
        chk("flush_dec_hazard", haz_seen, 1'b0);
        chk("flush_dec_issue", out_valid, 1'b1);
        idle();

        // Reset in the middle of a stall with a pending write.
        do_reset();
        wb_en = 1; wb_dest = 4'd2; wb_value = 32'd5; cyc();
        wb_en = 0;
        in_valid = 1;
        instruction = enc(AL, 2'd0, 0, 4'h4, 0, 2, 1, 12'h002);
        cyc();
        stall_in = 1;
        instruction = enc(AL, 2'd0, 0, 4'h2, 0, 1, 5, 12'h002);
        cyc();
        chk("pre_rst_hazard", haz_seen, 1'b1);
        rst = 1;
        cyc();
        chk("mid_rst_outs", pack_dut(), 156'h0);
        rst = 0; stall_in = 0;
        cyc();
        chk("post_rst2_hazard", haz_seen, 1'b0);
        chk("post_rst2_val_rn", val_rn, 32'd0);
        chk("post_rst2_val_rm", val_rm, 32'd0);
        idle();

        // Decode table, one instruction from a clean state each.
        for (int i = 0; i < 22; i++) begin
            do_reset();
            in_valid = 1;
            instruction = tbl[i].ins;
            status = tbl[i].st;
            cyc();
            chk($sformatf("vec%0d", i),
                {out_valid, exe_cmd, mem_r_en, mem_w_en, wb_en_out, branch, s_update},
                tbl[i].exp);
        end
        idle();

        // Random traffic against the model.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            logic [3:0]  cnd, op, a, d, m;
            logic [1:0]  md;
            logic [7:0]  hi;
            cnd = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : AL;
            md  = 2'($urandom_range(0, 3));
            op  = 4'($urandom_range(0, 15));
            a   = 4'($urandom_range(0, 7));
            d   = 4'($urandom_range(0, 7));
            m   = 4'($urandom_range(0, 7));
            hi  = 8'($urandom_range(0, 255));
            instruction = enc(cnd, md, 1'($urandom_range(0, 1)), op, 1'($urandom_range(0, 1)),
                              a, d, {hi, m});
            in_valid = ($urandom_range(0, 3) != 0);
            status   = 4'($urandom_range(0, 15));
            pc       = $urandom;
            stall_in = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 19) == 0);
            wb_en    = ($urandom_range(0, 1) == 1);
            wb_dest  = 4'($urandom_range(0, 7));
            wb_value = $urandom;
            rst      = ($urandom_range(0, 299) == 0);
            cyc();
        end
        idle();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
